program_loader: RTL and testbench

- Write-side counterpart of the instruction memory's load port.
- Receives a byte stream from the debug/UART unit, assembles 32-bit big-endian instructions, and drives the memory's write strobe, address and instruction inputs.
- Stops on a HALT word or when memory capacity is reached; signals completion so the CPU can be released from reset.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/loader_word_assembler.sv | 43 ++++
 rtl/program_loader.sv | 158 +++++++++++++++
 tb/tb_program_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: constants and FSM state type shared by the program loader and
// its word assembler.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHK state).
package mips_pkg;

    localparam int unsigned   NB_INST   = 32;
    localparam int unsigned   ADDR_STEP = 4;
    localparam logic [31:0]   HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
`ifdef LOADER_CHECKSUM_EN
        ,
        CHK
`endif
    } loader_state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// loader_word_assembler: shifts accepted bytes in on the LSB side, so the
// first byte of a word ends up in bits [31:24] (big-endian).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear           synchronous clear of the byte count and shift register
//   enable          bytes are accepted only while high
//   rx_data         incoming byte
//   rx_valid        rx_data strobe
//   word            shift register contents
//   word_ready      combinational pulse: the byte being accepted completes a word
module loader_word_assembler
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [NB_INST-1:0] word,
    output logic               word_ready
);

    logic [1:0] count;
    logic       take;

    assign take       = enable && rx_valid;
    assign word_ready = take && (count == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            word  <= '0;
        end else if (clear) begin
            count <= '0;
            word  <= '0;
        end else if (take) begin
            count <= count + 2'd1;
            word  <= {word[NB_INST-9:0], rx_data};
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: assembles a byte stream into 32-bit big-endian instructions
// and writes them into instruction memory at consecutive addresses, stopping
// on HALT_WORD or when the memory is full.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte,
// o_chk_error output, o_done delayed until the checksum byte arrives).
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_start          begin a new load at address 0 (from IDLE or DONE)
//   i_rx_data/valid  incoming byte and its strobe
//   o_write          one-cycle memory write strobe
//   o_address        write address (byte addressing)
//   o_instruction    assembled instruction
//   o_busy           load in progress
//   o_done           load finished, held until next i_start
//   o_overflow       memory filled before HALT_WORD was seen
//   o_chk_error      checksum mismatch (LOADER_CHECKSUM_EN only)
module program_loader
    import mips_pkg::*;
#(
    parameter int unsigned         NB_ADDR     = 32,
    parameter int unsigned         NB_INST     = mips_pkg::NB_INST,
    parameter int unsigned         NB_ROM_SIZE = 10,
    parameter int unsigned         ADDR_STEP   = mips_pkg::ADDR_STEP,
    parameter logic [NB_INST-1:0]  HALT_WORD   = mips_pkg::HALT_WORD
)(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_write,
    output logic [NB_ADDR-1:0] o_address,
    output logic [NB_INST-1:0] o_instruction,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic               o_chk_error
`endif
);

    // One extra bit so the capacity compare cannot wrap.
    localparam logic [NB_ADDR:0] STEP  = (NB_ADDR+1)'(ADDR_STEP);
    localparam logic [NB_ADDR:0] LIMIT = STEP << NB_ROM_SIZE;

    loader_state_t      state, state_next;
    logic [NB_ADDR-1:0] address;
    logic [NB_ADDR:0]   next_address;
    logic               overflow;
    logic               start_load;
    logic               asm_enable;
    logic               word_ready;
    logic [NB_INST-1:0] word;
    logic               is_halt;
    logic               at_capacity;
    logic               terminal;

    assign next_address = {1'b0, address} + STEP;
    assign at_capacity  = next_address >= LIMIT;
    assign is_halt      = word == HALT_WORD;
    assign terminal     = is_halt || at_capacity;
    assign start_load   = i_start && ((state == IDLE) || (state == DONE));
    // A byte arriving during a non-final WRITE starts the next word.
    assign asm_enable   = (state == RECV) || ((state == WRITE) && !terminal);

    loader_word_assembler u_assembler (
        .clk        (i_clk),
        .rst        (i_reset),
        .clear      (start_load),
        .enable     (asm_enable),
        .rx_data    (i_rx_data),
        .rx_valid   (i_rx_valid),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (i_start) state_next = RECV;
            end
            RECV: begin
                if (word_ready) state_next = WRITE;
            end
            WRITE: begin
                if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
`endif
                end else if (at_capacity) begin
                    state_next = DONE;
                end else begin
                    state_next = RECV;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (i_rx_valid) state_next = DONE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            address  <= '0;
            overflow <= 1'b0;
        end else if (start_load) begin
            address  <= '0;
            overflow <= 1'b0;
        end else if (state == WRITE) begin
            if (!terminal) address <= next_address[NB_ADDR-1:0];
            if (!is_halt && at_capacity) overflow <= 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_xor;
    logic       chk_error;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            chk_xor   <= '0;
            chk_error <= 1'b0;
        end else if (start_load) begin
            chk_xor   <= '0;
            chk_error <= 1'b0;
        end else if (asm_enable && i_rx_valid) begin
            chk_xor   <= chk_xor ^ i_rx_data;
        end else if ((state == CHK) && i_rx_valid) begin
            chk_error <= i_rx_data != chk_xor;
        end
    end

    assign o_chk_error = chk_error;
`endif

    assign o_write       = state == WRITE;
    assign o_busy        = (state == RECV) || (state == WRITE);
    assign o_done        = state == DONE;
    assign o_address     = address;
    assign o_instruction = word;
    assign o_overflow    = overflow;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a default-size instance and a 4-word instance
// share one stimulus stream; each is checked every cycle against a
// byte-stream reference model, plus a constant vector table and directed
// sequences for the multi-cycle corner cases.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;

    logic        w0, b0, d0, v0, w1, b1, d1, v1;
    logic [31:0] a0, n0, a1, n1;
`ifdef LOADER_CHECKSUM_EN
    logic        ce0, ce1;
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    program_loader dut (
        .i_clk(clk), .i_reset(rst), .i_start(i_start),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_write(w0), .o_address(a0), .o_instruction(n0),
        .o_busy(b0), .o_done(d0), .o_overflow(v0)
`ifdef LOADER_CHECKSUM_EN
        , .o_chk_error(ce0)
`endif
    );

    program_loader #(.NB_ROM_SIZE(2)) dut_small (
        .i_clk(clk), .i_reset(rst), .i_start(i_start),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_write(w1), .o_address(a1), .o_instruction(n1),
        .o_busy(b1), .o_done(d1), .o_overflow(v1)
`ifdef LOADER_CHECKSUM_EN
        , .o_chk_error(ce1)
`endif
    );

    // ---------------- reference model (one per instance) ----------------
    int unsigned limit_bytes [2] = '{4096, 16};
    bit          m_loading [2], m_write_now [2], m_done [2], m_ovf [2];
    bit          m_chk_wait [2], m_chk_err [2];
    int unsigned m_words [2], m_cnt [2];
    logic [7:0]  m_buf [2][4];
    logic [31:0] m_word [2];
    logic [7:0]  m_xor [2];

    logic [31:0] wr0_addr [$], wr0_data [$], wr1_addr [$];

    task automatic model_reset();
        for (int unsigned m = 0; m < 2; m++) begin
            m_loading[m] = 0; m_write_now[m] = 0; m_done[m] = 0; m_ovf[m] = 0;
            m_chk_wait[m] = 0; m_chk_err[m] = 0; m_words[m] = 0; m_cnt[m] = 0;
            m_word[m] = '0; m_xor[m] = '0;
        end
    endtask

    task automatic model_accept(input int unsigned m, input logic [7:0] data);
        m_xor[m] = m_xor[m] ^ data;
        m_buf[m][m_cnt[m]] = data;
        m_cnt[m]++;
        if (m_cnt[m] == 4) begin
            m_word[m] = {m_buf[m][0], m_buf[m][1], m_buf[m][2], m_buf[m][3]};
            m_cnt[m] = 0;
            m_write_now[m] = 1;
        end
    endtask

    task automatic model_step(input int unsigned m, input bit start, input bit valid,
                              input logic [7:0] data);
        bit halt, cap;
        if (m_write_now[m]) begin
            halt = m_word[m] == 32'hFFFF_FFFF;
            cap  = (m_words[m] + 1) * 4 >= limit_bytes[m];
            m_write_now[m] = 0;
            if (halt || cap) begin
                m_loading[m] = 0;
                if (halt && CHK_EN) m_chk_wait[m] = 1;
                else                m_done[m] = 1;
                m_ovf[m] = !halt;
            end else begin
                m_words[m]++;
                if (valid) model_accept(m, data);
            end
        end else if (m_loading[m]) begin
            if (valid) model_accept(m, data);
        end else if (m_chk_wait[m]) begin
            if (valid) begin
                m_chk_err[m]  = data != m_xor[m];
                m_chk_wait[m] = 0;
                m_done[m]     = 1;
            end
        end else if (start) begin
            m_loading[m] = 1; m_done[m] = 0; m_ovf[m] = 0; m_words[m] = 0;
            m_cnt[m] = 0; m_xor[m] = '0; m_chk_err[m] = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int unsigned m, input logic w, input logic b,
                              input logic d, input logic v, input logic [31:0] a,
                              input logic [31:0] n, input logic ce);
        string p;
        p = $sformatf("inst%0d", m);
        chk({p, " o_write"},    {31'd0, w}, {31'd0, m_write_now[m]});
        chk({p, " o_busy"},     {31'd0, b}, {31'd0, m_loading[m]});
        chk({p, " o_done"},     {31'd0, d}, {31'd0, m_done[m]});
        chk({p, " o_overflow"}, {31'd0, v}, {31'd0, m_ovf[m]});
        chk({p, " o_address"},  a, m_words[m] * 4);
        if (m_write_now[m]) chk({p, " o_instruction"}, n, m_word[m]);
`ifdef LOADER_CHECKSUM_EN
        chk({p, " o_chk_error"}, {31'd0, ce}, {31'd0, m_chk_err[m]});
`else
        if (ce) chk({p, " unused"}, 32'd0, 32'd0);
`endif
    endtask

    // Check current outputs, drive one cycle of inputs, advance the model.
    task automatic cycle(input bit start, input bit valid, input logic [7:0] data);
`ifdef LOADER_CHECKSUM_EN
        check_inst(0, w0, b0, d0, v0, a0, n0, ce0);
        check_inst(1, w1, b1, d1, v1, a1, n1, ce1);
`else
        check_inst(0, w0, b0, d0, v0, a0, n0, 1'b0);
        check_inst(1, w1, b1, d1, v1, a1, n1, 1'b0);
`endif
        if (w0) begin wr0_addr.push_back(a0); wr0_data.push_back(n0); end
        if (w1) wr1_addr.push_back(a1);
        i_start = start; i_rx_valid = valid; i_rx_data = data;
        model_step(0, start, valid, data);
        model_step(1, start, valid, data);
        @(negedge clk);
        i_start = 0; i_rx_valid = 0;
    endtask

    task automatic send_word(input logic [31:0] word, input bit gap);
        logic [31:0] w;
        w = word;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, w[31:24]);
            w = w << 8;
        end
        if (gap) cycle(0, 0, 8'h00);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst write",  {30'd0, w0, w1}, 32'd0);
        chk("rst busy",   {30'd0, b0, b1}, 32'd0);
        chk("rst done",   {30'd0, d0, d1}, 32'd0);
        chk("rst ovf",    {30'd0, v0, v1}, 32'd0);
        chk("rst addr",   a0 | a1, 32'd0);
        chk("rst inst",   n0 | n1, 32'd0);
        @(negedge clk);
        rst = 0;
        model_reset();
        wr0_addr.delete(); wr0_data.delete(); wr1_addr.delete();
    endtask

    typedef struct {
        bit          start;
        bit          valid;
        logic [7:0]  data;
        bit          exp_write;
        bit          exp_busy;
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs [6];

    initial begin
        rst = 1; i_start = 0; i_rx_valid = 0; i_rx_data = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset in the middle of RECV after two bytes.
        cycle(1, 0, 8'h00);
        cycle(0, 1, 8'hAB);
        cycle(0, 1, 8'hCD);
        do_reset();

        // Constant vector table: load 00 43 08 21.
        vecs[0] = '{1, 0, 8'h00, 0, 1, 32'd0, 32'h0000_0000};
        vecs[1] = '{0, 1, 8'h00, 0, 1, 32'd0, 32'h0000_0000};
        vecs[2] = '{0, 1, 8'h43, 0, 1, 32'd0, 32'h0000_0043};
        vecs[3] = '{0, 1, 8'h08, 0, 1, 32'd0, 32'h0000_4308};
        vecs[4] = '{0, 1, 8'h21, 1, 1, 32'd0, 32'h0043_0821};
        vecs[5] = '{0, 0, 8'h00, 0, 1, 32'd4, 32'h0043_0821};
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].start, vecs[i].valid, vecs[i].data);
            chk($sformatf("vec%0d write", i), {31'd0, w0}, {31'd0, vecs[i].exp_write});
            chk($sformatf("vec%0d busy", i),  {31'd0, b0}, {31'd0, vecs[i].exp_busy});
            chk($sformatf("vec%0d addr", i),  a0, vecs[i].exp_addr);
            chk($sformatf("vec%0d inst", i),  n0, vecs[i].exp_inst);
        end

        // Three words then HALT; both sizes end on HALT at address 12.
        do_reset();
        cycle(1, 0, 8'h00);
        send_word(32'h1122_3344, 1);
        send_word(32'hA5A5_A5A5, 1);
        send_word(32'h0000_0001, 1);
        send_word(32'hFFFF_FFFF, 0);
        cycle(0, 0, 8'h00);
`ifdef LOADER_CHECKSUM_EN
        chk("halt done before chk", {31'd0, d0}, 32'd0);
        cycle(0, 1, 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h01);
        chk("chk ok error", {31'd0, ce0}, 32'd0);
`endif
        chk("halt done", {31'd0, d0}, 32'd1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'h5A);
        chk("halt writes", wr0_addr.size(), 32'd4);
        chk("halt small writes", wr1_addr.size(), 32'd4);
        if (wr0_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("halt addr%0d", i), wr0_addr[i], 32'(i * 4));
            chk("halt last data", wr0_data[3], 32'hFFFF_FFFF);
        end
        chk("halt small ovf", {31'd0, v1}, 32'd0);

        // Back-to-back bytes, one landing in WRITE.
        do_reset();
        cycle(1, 0, 8'h00);
        send_word(32'h8C01_002A, 0);
        send_word(32'h2042_0005, 0);
        cycle(0, 0, 8'h00);
        chk("b2b writes", wr0_data.size(), 32'd2);
        if (wr0_data.size() == 2) begin
            chk("b2b data0", wr0_data[0], 32'h8C01_002A);
            chk("b2b data1", wr0_data[1], 32'h2042_0005);
            chk("b2b addr1", wr0_addr[1], 32'd4);
        end

        // Capacity: 17 back-to-back bytes, no HALT.
        do_reset();
        cycle(1, 0, 8'h00);
        for (int i = 0; i < 17; i++) cycle(0, 1, 8'(8'h10 + i));
        cycle(0, 0, 8'h00);
        cycle(0, 0, 8'h00);
        chk("ovf small writes", wr1_addr.size(), 32'd4);
        chk("ovf small flag", {31'd0, v1}, 32'd1);
        chk("ovf small done", {31'd0, d1}, 32'd1);
        chk("ovf small addr", a1, 32'd12);
        chk("ovf big flag", {31'd0, v0}, 32'd0);
        chk("ovf big writes", wr0_addr.size(), 32'd4);

        // i_start ignored in RECV, honoured in DONE.
        do_reset();
        cycle(1, 0, 8'h00);
        cycle(0, 1, 8'h01);
        cycle(0, 1, 8'h02);
        cycle(1, 1, 8'h03);
        cycle(1, 1, 8'h04);
        cycle(0, 0, 8'h00);
        chk("start recv write", wr0_data.size(), 32'd1);
        if (wr0_data.size() == 1) chk("start recv data", wr0_data[0], 32'h0102_0304);
        send_word(32'hFFFF_FFFF, 1);
`ifdef LOADER_CHECKSUM_EN
        cycle(0, 1, 8'h05);
        chk("chk bad error", {31'd0, ce0}, 32'd1);
`endif
        chk("start done set", {31'd0, d0}, 32'd1);
        chk("start done addr", a0, 32'd4);
        cycle(1, 0, 8'h00);
        chk("restart done", {31'd0, d0}, 32'd0);
        chk("restart addr", a0, 32'd0);
        chk("restart busy", {31'd0, b0}, 32'd1);

        // Randomized stream against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit          s, v;
            logic [7:0]  d;
            s = ($urandom_range(0, 63) == 0);
            v = ($urandom_range(0, 1) == 1);
            d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            cycle(s, v, d);
        end
        cycle(0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
